nco_phase_gen: RTL

Numerically-controlled phase generator that produces the phase-word stream consumed by the sine lookup table in the DSP filter test chain. Contains a programmable phase accumulator with a valid/ready output handshake, burst or continuous operation, and glitch-free frequency updates committed at phase wrap. Sits upstream of the sine table: its `o_phase` drives the table's 8-bit data input.

---
 rtl/nco_phase_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/nco_phase_gen.sv
// Phase accumulator feeding the sine table: valid/ready sample stream, burst or
// continuous runs, and frequency changes that take effect only at phase wrap.
module nco_phase_gen #(
  parameter int PW = 24,
  parameter int OW = 8,
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_freq_we,
  input  logic [PW-1:0] i_freq,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [CW-1:0] i_count,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [OW-1:0] o_phase,
  output logic          o_wrap,
  output logic          o_busy,
  output logic          o_done
);

  // state   | meaning
  // ST_IDLE | no run active, o_valid low, waiting for i_start
  // ST_RUN  | presenting samples; ends on last burst transfer or after stop
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] acc;
  logic [PW-1:0] freq_act;
  logic [PW-1:0] freq_shd;
  logic [CW-1:0] cnt;
  logic          stop_pend;

  logic [PW:0]   sum;
  logic [PW-1:0] freq_next;
  logic          xfer;
  logic          last;

  assign sum       = {1'b0, acc} + {1'b0, freq_act};
  // A write in the same cycle as a commit point bypasses the shadow register.
  assign freq_next = i_freq_we ? i_freq : freq_shd;
  assign xfer      = o_valid & i_ready;
  // cnt stays 0 in continuous mode, so only a burst can hit the terminal count.
  assign last      = xfer & ((cnt == CW'(1)) | stop_pend | i_stop);

  assign o_phase = acc[PW-1:PW-OW];
  assign o_busy  = (state == ST_RUN);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      freq_act  <= '0;
      freq_shd  <= '0;
      cnt       <= '0;
      stop_pend <= 1'b0;
      o_valid   <= 1'b0;
      o_wrap    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_freq_we) freq_shd <= i_freq;

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state     <= ST_RUN;
            acc       <= '0;
            freq_act  <= freq_next;
            cnt       <= i_count;
            stop_pend <= 1'b0;
            o_valid   <= 1'b1;
            o_wrap    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            acc <= sum[PW-1:0];
            if (sum[PW]) freq_act <= freq_next;
            if (cnt != '0) cnt <= cnt - CW'(1);
          end
          if (last) begin
            state     <= ST_IDLE;
            stop_pend <= 1'b0;
            o_valid   <= 1'b0;
            o_wrap    <= 1'b0;
            o_done    <= 1'b1;
          end else begin
            if (xfer) o_wrap <= sum[PW];
            if (i_stop) stop_pend <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
